// File: rtl/product_accumulator.sv
// Accumulates a run of len unsigned products from the upstream multiplier
// and presents the modulo-2^AW sum plus a sticky carry-out flag.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the previous result
// ACCUM | accepting products until the remaining count reaches zero
// DONE  | result presented, waiting for out_ready
module product_accumulator #(
    parameter int PW = 8,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    cnt, cnt_nxt;
    logic [AW-1:0] acc, acc_nxt;
    logic          ovf, ovf_nxt;
    logic          accept;
    logic [AW:0]   sum_ext;

    // in_ready is a flop that is high exactly while state is ACCUM
    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, in_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt   = (len == 4'd0) ? 5'd16 : {1'b0, len};
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = sum_ext[AW-1:0];
                    ovf_nxt = ovf | sum_ext[AW];
                    cnt_nxt = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The accumulator itself is the result; it is only cleared by start or reset
    assign out_sum = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 12-bit and a 10-bit accumulator
// share one stimulus stream so every run checks both widths.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic        out_ready;

    logic        in_ready12, out_valid12, out_ovf12, busy12;
    logic [11:0] out_sum12;
    logic        in_ready10, out_valid10, out_ovf10, busy10;
    logic [9:0]  out_sum10;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PW(8), .AW(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready12), .in_prod(in_prod),
        .out_valid(out_valid12), .out_ready(out_ready),
        .out_sum(out_sum12), .out_ovf(out_ovf12), .busy(busy12)
    );

    product_accumulator #(.PW(8), .AW(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready10), .in_prod(in_prod),
        .out_valid(out_valid10), .out_ready(out_ready),
        .out_sum(out_sum10), .out_ovf(out_ovf10), .busy(busy10)
    );

    typedef struct packed {
        logic [3:0]  len;
        logic [4:0]  n;
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic [7:0]  pc;
        logic        bub;
        logic [11:0] e12;
        logic        o12;
        logic [9:0]  e10;
        logic        o10;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(logic [3:0] l, logic [4:0] n, logic [7:0] a, logic [7:0] b,
                                 logic [7:0] c, logic bub, logic [11:0] e12, logic o12,
                                 logic [9:0] e10, logic o10);
        vec_t v;
        v.len = l; v.n = n; v.pa = a; v.pb = b; v.pc = c; v.bub = bub;
        v.e12 = e12; v.o12 = o12; v.e10 = e10; v.o10 = o10;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int acc_n = 0;
        int cyc = 0;
        start = 1'b1;
        len   = v.len;
        step();
        start = 1'b0;
        chk("run_busy", {31'd0, busy12}, 32'd1);
        chk("run_out_valid_low", {30'd0, out_valid12, out_valid10}, 32'd0);
        while (acc_n < int'(v.n) && cyc < 200) begin
            if (!in_ready12 || !in_ready10)
                chk("run_in_ready", {30'd0, in_ready12, in_ready10}, 32'd3);
            in_valid = v.bub ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_prod  = (acc_n == 0) ? v.pa : (acc_n == 1) ? v.pb : v.pc;
            step();
            if (in_valid) acc_n++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 200) chk("run_beat_timeout", cyc, 32'd0);
        chk("run_out_valid", {30'd0, out_valid12, out_valid10}, 32'd3);
        chk("run_in_ready_done", {30'd0, in_ready12, in_ready10}, 32'd0);
        chk("run_sum12", {20'd0, out_sum12}, {20'd0, v.e12});
        chk("run_ovf12", {31'd0, out_ovf12}, {31'd0, v.o12});
        chk("run_sum10", {22'd0, out_sum10}, {22'd0, v.e10});
        chk("run_ovf10", {31'd0, out_ovf10}, {31'd0, v.o10});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("run_idle", {29'd0, busy12, busy10, out_valid12}, 32'd0);
        chk("run_sum_retained", {20'd0, out_sum12}, {20'd0, v.e12});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 4'd0; in_valid = 1'b0;
        in_prod = 8'd0; out_ready = 1'b0;

        vecs[0] = mkv(4'd4,  5'd4,  8'd225, 8'd225, 8'd225, 1'b0, 12'd900,  1'b0, 10'd900, 1'b0);
        vecs[1] = mkv(4'd0,  5'd16, 8'd255, 8'd255, 8'd255, 1'b1, 12'd4080, 1'b0, 10'd1008, 1'b1);
        vecs[2] = mkv(4'd5,  5'd5,  8'd255, 8'd255, 8'd255, 1'b0, 12'd1275, 1'b0, 10'd251, 1'b1);
        vecs[3] = mkv(4'd1,  5'd1,  8'd10,  8'd10,  8'd10,  1'b0, 12'd10,   1'b0, 10'd10,  1'b0);
        vecs[4] = mkv(4'd2,  5'd2,  8'd3,   8'd4,   8'd4,   1'b0, 12'd7,    1'b0, 10'd7,   1'b0);
        vecs[5] = mkv(4'd3,  5'd3,  8'd1,   8'd2,   8'd3,   1'b1, 12'd6,    1'b0, 10'd6,   1'b0);
        vecs[6] = mkv(4'd15, 5'd15, 8'd200, 8'd200, 8'd200, 1'b1, 12'd3000, 1'b0, 10'd952, 1'b1);

        #3;
        chk("reset_outputs12", {16'd0, out_sum12, out_ovf12, out_valid12, in_ready12, busy12}, 32'd0);
        chk("reset_outputs10", {18'd0, out_sum10, out_ovf10, out_valid10, in_ready10, busy10}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Result held in DONE while start is pulsed
        start = 1'b1; len = 4'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 8'd100; step();
        in_prod = 8'd28; step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            start = (k == 3);
            len   = 4'd1;
            step();
            chk("hold_state", {29'd0, out_valid12, busy12, in_ready12}, 32'd6);
            chk("hold_sum", {20'd0, out_sum12}, 32'd128);
            chk("hold_ovf", {31'd0, out_ovf12}, 32'd0);
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_release", {30'd0, busy12, out_valid12}, 32'd0);

        // in_valid in IDLE must not touch the retained result
        in_valid = 1'b1; in_prod = 8'd77;
        repeat (3) step();
        in_valid = 1'b0;
        chk("idle_valid_sum", {20'd0, out_sum12}, 32'd128);
        chk("idle_valid_busy", {30'd0, busy12, in_ready12}, 32'd0);

        // Asynchronous reset mid-run
        start = 1'b1; len = 4'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 8'd50;
        repeat (2) step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset12", {16'd0, out_sum12, out_ovf12, out_valid12, in_ready12, busy12}, 32'd0);
        chk("midrun_reset10", {18'd0, out_sum10, out_ovf10, out_valid10, in_ready10, busy10}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; len = 4'd1;
        step();
        start = 1'b0;
        chk("post_reset_start", {30'd0, busy12, in_ready12}, 32'd3);
        in_valid = 1'b1; in_prod = 8'd9;
        step();
        in_valid = 1'b0;
        chk("post_reset_valid", {31'd0, out_valid12}, 32'd1);
        chk("post_reset_sum", {20'd0, out_sum12}, 32'd9);
        chk("post_reset_ovf", {30'd0, out_ovf12, out_ovf10}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_reset_idle", {31'd0, busy12}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL be parameterised by `PW`, default 8: product input width, matching the 4-bit x 4-bit multiplier output.
REQ-002 The block SHALL be parameterised by `AW`, default 12: accumulator width, with `AW` >= `PW`.
REQ-003 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-004 `clk`  input  1  sole clock; all state updates on its rising edge.
REQ-005 `rst_n`  input  1  asynchronous active-low reset.
REQ-006 `start`  input  1  single-cycle request to begin one accumulation run.
REQ-007 `len`  input  4  number of products in the run; 0 encodes 16.
REQ-008 `in_valid`  input  1  `in_prod` holds a valid product this cycle.
REQ-009 `in_ready`  output  1  block accepts a product this cycle.
REQ-010 `in_prod`  input  `PW`  unsigned product from the upstream multiplier.
REQ-011 `out_valid`  output  1  `out_sum` and `out_ovf` hold a completed result.
REQ-012 `out_ready`  input  1  downstream consumes the result.
REQ-013 `out_sum`  output  `AW`  accumulated sum, modulo 2^`AW`.
REQ-014 `out_ovf`  output  1  sticky flag: at least one addition in the run carried out of `AW` bits.
REQ-015 `busy`  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCUM and DONE, encoded in registers.
REQ-017 In IDLE, `in_ready`, `out_valid` and `busy` SHALL be 0.
REQ-018 In IDLE, `start`=1 SHALL load the remaining count from `len` (0 loads 16), clear the accumulator and the overflow flag, and move to ACCUM on the next edge.
REQ-019 `start` SHALL be ignored in ACCUM and DONE; it SHALL not restart, extend or corrupt a run.
REQ-020 In ACCUM, `in_ready` SHALL be 1 as a registered, state-decoded output, with no combinational path from any input to `in_ready`.
REQ-021 A beat SHALL be accepted only on an edge where `in_valid` and `in_ready` are both 1. Each accepted beat: acc <= (acc + zero-extended `in_prod`) mod 2^`AW`; ovf <= ovf OR carry-out; remaining count decrements by 1.
REQ-022 Edges in ACCUM with `in_valid`=0 SHALL leave all state unchanged; bubbles of any length are permitted.
REQ-023 Acceptance of the beat that brings the remaining count to 0 SHALL move the FSM to DONE, so `out_valid` rises 1 cycle after the last accepted beat.
REQ-024 In ACCUM, `out_valid` SHALL be 0.
REQ-025 In DONE, `out_valid` SHALL be 1 and `in_ready` SHALL be 0.
REQ-026 In DONE, `out_sum` and `out_ovf` SHALL hold stable until the result is consumed.
REQ-027 In DONE, `out_ready`=1 SHALL return the FSM to IDLE on that edge.
REQ-028 In DONE, `out_ready`=0 SHALL hold the FSM in DONE indefinitely.
REQ-029 `out_sum` and `out_ovf` SHALL retain their last values in IDLE until the next `start` clears them.
REQ-030 Input `in_valid` asserted outside ACCUM SHALL have no effect.
REQ-031 The minimum run SHALL be 1 start cycle + `len` accepted beats + 1 DONE cycle. Back-to-back runs are allowed: `start` is accepted in the first IDLE cycle after a handshake.

Reset
REQ-032 While `rst_n`=0, the FSM SHALL be IDLE and the accumulator, remaining count, `out_sum`, `out_ovf`, `out_valid`, `in_ready` and `busy` SHALL all be 0, independent of `clk`.
REQ-033 Assertion of `rst_n` mid-run (in ACCUM or DONE) SHALL abandon the run immediately, with no partial result presented afterwards.
REQ-034 After deassertion of `rst_n`, the block SHALL respond to `start` on the first rising edge.

Verification
REQ-035 Scenario: `len`=4, products 225,225,225,225 with no bubbles -> `out_valid` 1 cycle after the 4th beat, `out_sum`=900, `out_ovf`=0.
REQ-036 Scenario: `len`=0 (=16), 16 beats of 255 with random `in_valid` bubbles -> exactly 16 beats accepted, `out_sum`=4080, `out_ovf`=0.
REQ-037 Scenario: `AW`=10, `len`=5, 5 beats of 255 -> `out_sum`=251 (1275 mod 1024), `out_ovf`=1.
REQ-038 Scenario: result ready, `out_ready` held 0 for 7 cycles, `start` pulsed during DONE -> `out_valid`, `out_sum` and `out_ovf` stable for those 7 cycles, `start` ignored, IDLE after `out_ready`=1.
REQ-039 Scenario: `rst_n` pulsed low after 2 of 3 beats -> all outputs 0 immediately; a new run with `len`=1 and product 9 gives `out_sum`=9.
REQ-040 Scenario: back-to-back runs (`len`=1, product 10; then `len`=2, products 3 and 4) -> sums 10 then 7, with no cross-run carry of sum or ovf.
